// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register indices and the
// write-back run/halt state encoding.
package y86_pkg;

  localparam int DATA_W = 64;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'd4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } wb_state_e;

  // An index names a real register only if it is not the "none" code and fits the file.
  function automatic logic reg_writable(input logic [3:0] idx, input int num_regs);
    return (idx != REG_NONE) && (int'(idx) < num_regs);
  endfunction

endpackage

// File: rtl/wb_dst_decode.sv
// Destination decode for write-back: maps {icode, rA, rB, cnd} to the E and M
// destination register indices. Purely combinational so execute can reuse it.
module wb_dst_decode
  import y86_pkg::*;
#(
  parameter logic [3:0] RSP_IDX = REG_RSP
) (
  input  logic [3:0] icode,
  input  logic [3:0] ra,
  input  logic [3:0] rb,
  input  logic       cnd,
  output logic [3:0] dst_e,
  output logic [3:0] dst_m
);

  always_comb begin
    dst_e = REG_NONE;
    case (icode)
      I_RRMOVQ:                        dst_e = cnd ? rb : REG_NONE;
      I_IRMOVQ, I_OPQ:                 dst_e = rb;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:  dst_e = RSP_IDX;
      default:                         dst_e = REG_NONE;
    endcase
  end

  always_comb begin
    dst_m = REG_NONE;
    case (icode)
      I_MRMOVQ, I_POPQ: dst_m = ra;
      default:          dst_m = REG_NONE;
    endcase
  end

endmodule

// File: rtl/regfile_writeback.sv
// SEQ Y86-64 write-back stage: architectural register file, retired-instruction
// counter and the run/halt state that blocks commits after a halt or fault.
module regfile_writeback #(
  parameter int         DATA_W   = y86_pkg::DATA_W,
  parameter int         NUM_REGS = 15,
  parameter logic [3:0] RSP_IDX  = y86_pkg::REG_RSP
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wb_valid,
  input  logic [3:0]                   icode,
  input  logic [3:0]                   rA,
  input  logic [3:0]                   rB,
  input  logic                         cnd,
  input  logic                         instr_err,
  input  logic [DATA_W-1:0]            valE,
  input  logic [DATA_W-1:0]            valM,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic [3:0]                   dstE,
  output logic [3:0]                   dstM,
  output logic                         halted,
  output logic [31:0]                  retired
);
  import y86_pkg::*;

  wb_state_e         state_q, state_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [31:0]       retired_q, retired_d;
  logic [3:0]        dec_dst_e, dec_dst_m;
  logic              live, halt_evt, commit;

  wb_dst_decode #(.RSP_IDX(RSP_IDX)) u_dst_decode (
    .icode (icode),
    .ra    (rA),
    .rb    (rB),
    .cnd   (cnd),
    .dst_e (dec_dst_e),
    .dst_m (dec_dst_m)
  );

  // A retiring instruction either halts the core or commits, never both.
  always_comb begin
    live     = wb_valid && (state_q == ST_RUN);
    halt_evt = live && ((icode == I_HALT) || instr_err);
    commit   = live && !halt_evt;
    dstE     = live ? dec_dst_e : REG_NONE;
    dstM     = live ? dec_dst_m : REG_NONE;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (halt_evt) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    halted = (state_q == ST_HALT);
  end

  // M write is applied after E so popq %rsp leaves the loaded value in %rsp.
  always_comb begin
    regs_d    = regs_q;
    retired_d = retired_q;
    if (commit) begin
      if (reg_writable(dstE, NUM_REGS)) regs_d[dstE] = valE;
      if (reg_writable(dstM, NUM_REGS)) regs_d[dstM] = valM;
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      retired_q <= retired_d;
      regs_q    <= regs_d;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
    retired = retired_q;
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed table-driven bench for regfile_writeback with hand-computed results,
// plus hand-written reset, halt and fault sequences.
module tb_regfile_writeback;

  localparam int DW = 64;
  localparam int NR = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              wb_valid;
  logic [3:0]        icode, rA, rB;
  logic              cnd, instr_err;
  logic [DW-1:0]     valE, valM;
  logic [NR*DW-1:0]  regs_flat;
  logic [3:0]        dstE, dstM;
  logic              halted;
  logic [31:0]       retired;

  regfile_writeback #(.DATA_W(DW), .NUM_REGS(NR), .RSP_IDX(4'd4)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_valid  (wb_valid),
    .icode     (icode),
    .rA        (rA),
    .rB        (rB),
    .cnd       (cnd),
    .instr_err (instr_err),
    .valE      (valE),
    .valM      (valM),
    .regs_flat (regs_flat),
    .dstE      (dstE),
    .dstM      (dstM),
    .halted    (halted),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb_valid;
    logic [3:0]  icode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        cnd;
    logic        err;
    logic [63:0] vale;
    logic [63:0] valm;
    logic [3:0]  exp_dste;
    logic [3:0]  exp_dstm;
    logic [3:0]  ia;       // expected write A (F = none)
    logic [63:0] va;
    logic [3:0]  ib;       // expected write B (F = none), applied after A
    logic [63:0] vb;
    logic [31:0] exp_ret;
    logic        exp_halt;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_regs [NR];
  vec_t vecs [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_regs(input string tag);
    for (int i = 0; i < NR; i++)
      chk($sformatf("%s reg%0d", tag, i), regs_flat[i*DW +: DW], exp_regs[i]);
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF;
    cnd = 1'b0; instr_err = 1'b0; valE = '0; valM = '0;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    wb_valid = v.wb_valid; icode = v.icode; rA = v.ra; rB = v.rb;
    cnd = v.cnd; instr_err = v.err; valE = v.vale; valM = v.valm;
    #1;
    chk({tag, " dstE"}, 64'(dstE), 64'(v.exp_dste));
    chk({tag, " dstM"}, 64'(dstM), 64'(v.exp_dstm));
    @(posedge clk);
    #1;
    idle_inputs();
    if (v.ia != 4'hF) exp_regs[v.ia] = v.va;
    if (v.ib != 4'hF) exp_regs[v.ib] = v.vb;
    chk_all_regs(tag);
    chk({tag, " retired"}, 64'(retired), 64'(v.exp_ret));
    chk({tag, " halted"},  64'(halted),  64'(v.exp_halt));
  endtask

  task automatic do_reset(input logic with_write);
    reset = 1'b1;
    if (with_write) begin
      wb_valid = 1'b1; icode = 4'h3; rB = 4'd9; valE = 64'hBAD;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'h3, 4'hF, 4'd9, 1'b0, 1'b0, 64'h1234, 64'h0,
                 4'd9, 4'hF, 4'd9, 64'h1234, 4'hF, 64'h0, 32'd1, 1'b0};
    vecs[1]  = '{1'b1, 4'h2, 4'd3, 4'd5, 1'b0, 1'b0, 64'h7, 64'h0,
                 4'hF, 4'hF, 4'hF, 64'h0, 4'hF, 64'h0, 32'd2, 1'b0};
    vecs[2]  = '{1'b1, 4'h2, 4'd3, 4'd5, 1'b1, 1'b0, 64'h7, 64'h0,
                 4'd5, 4'hF, 4'd5, 64'h7, 4'hF, 64'h0, 32'd3, 1'b0};
    vecs[3]  = '{1'b1, 4'hB, 4'd4, 4'hF, 1'b0, 1'b0, 64'h108, 64'hDEAD,
                 4'd4, 4'd4, 4'd4, 64'hDEAD, 4'hF, 64'h0, 32'd4, 1'b0};
    vecs[4]  = '{1'b1, 4'hB, 4'd2, 4'hF, 1'b0, 1'b0, 64'h208, 64'h55,
                 4'd4, 4'd2, 4'd4, 64'h208, 4'd2, 64'h55, 32'd5, 1'b0};
    vecs[5]  = '{1'b1, 4'h8, 4'hF, 4'hF, 1'b0, 1'b0, 64'h1F8, 64'h3333,
                 4'd4, 4'hF, 4'd4, 64'h1F8, 4'hF, 64'h0, 32'd6, 1'b0};
    vecs[6]  = '{1'b1, 4'h5, 4'd7, 4'd3, 1'b0, 1'b0, 64'h100, 64'hABC,
                 4'hF, 4'd7, 4'd7, 64'hABC, 4'hF, 64'h0, 32'd7, 1'b0};
    vecs[7]  = '{1'b0, 4'h3, 4'hF, 4'd6, 1'b0, 1'b0, 64'h77, 64'h0,
                 4'hF, 4'hF, 4'hF, 64'h0, 4'hF, 64'h0, 32'd7, 1'b0};
    vecs[8]  = '{1'b1, 4'h3, 4'hF, 4'hF, 1'b0, 1'b0, 64'h5, 64'h0,
                 4'hF, 4'hF, 4'hF, 64'h0, 4'hF, 64'h0, 32'd8, 1'b0};
    vecs[9]  = '{1'b1, 4'h4, 4'd1, 4'd2, 1'b0, 1'b0, 64'h99, 64'h88,
                 4'hF, 4'hF, 4'hF, 64'h0, 4'hF, 64'h0, 32'd9, 1'b0};
    vecs[10] = '{1'b1, 4'h6, 4'hF, 4'd14, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                 4'd14, 4'hF, 4'd14, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 64'h0, 32'd10, 1'b0};
    vecs[11] = '{1'b1, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 64'h0, 64'h0,
                 4'hF, 4'hF, 4'hF, 64'h0, 4'hF, 64'h0, 32'd10, 1'b1};
    vecs[12] = '{1'b1, 4'h6, 4'hF, 4'd1, 1'b0, 1'b0, 64'h9, 64'h0,
                 4'hF, 4'hF, 4'hF, 64'h0, 4'hF, 64'h0, 32'd10, 1'b1};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);
    chk_all_regs("init");
    chk("init retired", 64'(retired), 64'd0);
    chk("init halted",  64'(halted),  64'd0);

    for (int k = 0; k < 13; k++) run_vec($sformatf("v%0d", k), vecs[k]);

    // Reset while halted, with a competing write in the same cycle.
    do_reset(1'b1);
    chk_all_regs("rst");
    chk("rst retired", 64'(retired), 64'd0);
    chk("rst halted",  64'(halted),  64'd0);

    run_vec("post_rst", '{1'b1, 4'h6, 4'hF, 4'd1, 1'b0, 1'b0, 64'h9, 64'h0,
                          4'd1, 4'hF, 4'd1, 64'h9, 4'hF, 64'h0, 32'd1, 1'b0});

    // A faulting instruction halts without writing and without retiring.
    run_vec("fault", '{1'b1, 4'h3, 4'hF, 4'd2, 1'b0, 1'b1, 64'h3, 64'h0,
                       4'd2, 4'hF, 4'hF, 64'h0, 4'hF, 64'h0, 32'd1, 1'b1});
    run_vec("after_fault", '{1'b1, 4'hA, 4'd1, 4'hF, 1'b0, 1'b0, 64'h40, 64'h0,
                             4'hF, 4'hF, 4'hF, 64'h0, 4'hF, 64'h0, 32'd1, 1'b1});

    do_reset(1'b0);
    chk_all_regs("rst2");
    chk("rst2 halted", 64'(halted), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
